// File: rtl/rvx_core_state_ctrl_pkg.sv
// rtl/rvx_core_state_ctrl_pkg.sv - shared core-state encodings for the RVX stage-1 state controller
//
// Provides:
//   RVX_STATE_W  - width of the core state encoding
//   rvx_state_e  - the six legal core states; encodings 6-15 are illegal
//   rvx_max      - integer max, used to size the dwell counter
package rvx_core_state_ctrl_pkg;

  localparam int RVX_STATE_W = 4;

  typedef enum logic [RVX_STATE_W-1:0] {
    RVX_STATE_RESET       = 4'd0,
    RVX_STATE_OPERATING   = 4'd1,
    RVX_STATE_TRAP_TAKEN  = 4'd2,
    RVX_STATE_TRAP_RETURN = 4'd3,
    RVX_STATE_WFI_SLEEP   = 4'd4,
    RVX_STATE_DEBUG_HALT  = 4'd5
  } rvx_state_e;

  function automatic int rvx_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rvx_core_state_ctrl.sv
// rtl/rvx_core_state_ctrl.sv - RVX stage-1 pipeline-state FSM with reset/trap dwell, WFI sleep and debug halt
//
// Ports:
//   clock             in   core clock
//   reset             in   synchronous, active-high reset
//   clock_enable      in   FSM and dwell counter advance only when high
//   mret_s1           in   MRET retiring in stage 1
//   take_trap_s1      in   trap/interrupt accepted in stage 1
//   wfi_s1            in   WFI retiring in stage 1
//   interrupt_pending in   any enabled interrupt pending (level)
//   halt_req          in   debug halt request (level)
//   resume_req        in   debug resume request
//   core_state_s1     out  current state encoding
//   flush_pipeline_s1 out  high whenever state != OPERATING
//   sleeping          out  high in WFI_SLEEP
//   halted            out  high in DEBUG_HALT
module rvx_core_state_ctrl
  import rvx_core_state_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter bit ENABLE_WFI   = 1'b1,
  parameter bit ENABLE_DEBUG = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clock_enable,
  input  logic                   mret_s1,
  input  logic                   take_trap_s1,
  input  logic                   wfi_s1,
  input  logic                   interrupt_pending,
  input  logic                   halt_req,
  input  logic                   resume_req,
  output logic [RVX_STATE_W-1:0] core_state_s1,
  output logic                   flush_pipeline_s1,
  output logic                   sleeping,
  output logic                   halted
);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("rvx_core_state_ctrl: RESET_CYCLES must be >= 1");
  end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("rvx_core_state_ctrl: FLUSH_CYCLES must be >= 1");
  end

  // Counter holds N-1 down to 0, so it needs to represent max(N) only.
  localparam int CNT_W = $clog2(rvx_max(rvx_max(RESET_CYCLES, FLUSH_CYCLES), 1) + 1);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  rvx_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic halt_en;
  logic wfi_en;

  assign halt_en = halt_req && ENABLE_DEBUG;
  assign wfi_en  = wfi_s1 && ENABLE_WFI;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RVX_STATE_RESET;
      cnt_q   <= RST_LOAD;
    end else if (clock_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      // Dwell states ignore every request until the counter runs out; a
      // pending halt is picked up on the first OPERATING cycle instead.
      RVX_STATE_RESET,
      RVX_STATE_TRAP_TAKEN,
      RVX_STATE_TRAP_RETURN: begin
        if (cnt_q == '0) begin
          state_d = RVX_STATE_OPERATING;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RVX_STATE_OPERATING: begin
        if (halt_en) begin
          state_d = RVX_STATE_DEBUG_HALT;
        end else if (take_trap_s1) begin
          state_d = RVX_STATE_TRAP_TAKEN;
          cnt_d   = FLUSH_LOAD;
        end else if (mret_s1) begin
          state_d = RVX_STATE_TRAP_RETURN;
          cnt_d   = FLUSH_LOAD;
        end else if (wfi_en && !interrupt_pending) begin
          // A WFI that already sees a pending interrupt would wake at once,
          // so it is treated as a no-op.
          state_d = RVX_STATE_WFI_SLEEP;
        end
      end

      RVX_STATE_WFI_SLEEP: begin
        if (halt_en) begin
          state_d = RVX_STATE_DEBUG_HALT;
        end else if (interrupt_pending) begin
          // Wake only; the trap itself arrives via take_trap_s1 once operating.
          state_d = RVX_STATE_OPERATING;
        end
      end

      RVX_STATE_DEBUG_HALT: begin
        // A still-asserted halt_req dominates resume_req.
        if (resume_req && !halt_req) begin
          state_d = RVX_STATE_OPERATING;
        end
      end

      default: begin
        state_d = RVX_STATE_RESET;
        cnt_d   = RST_LOAD;
      end
    endcase
  end

  assign core_state_s1     = state_q;
  assign flush_pipeline_s1 = (state_q != RVX_STATE_OPERATING);
  assign sleeping          = (state_q == RVX_STATE_WFI_SLEEP);
  assign halted            = (state_q == RVX_STATE_DEBUG_HALT);

endmodule

// File: tb/tb_rvx_core_state_ctrl.sv
// tb/tb_rvx_core_state_ctrl.sv - scoreboard bench for rvx_core_state_ctrl
module tb_rvx_core_state_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: RESET_CYCLES=3, FLUSH_CYCLES=4, WFI and debug enabled.
  logic       reset, clock_enable, mret, take_trap, wfi, irq, halt_req, resume_req;
  logic [3:0] state_a;
  logic       flush_a, sleep_a, halted_a;

  // Instance B: RESET_CYCLES=1, FLUSH_CYCLES=2, WFI and debug disabled.
  logic       reset_b, trap_b, wfi_b, halt_b;
  logic [3:0] state_b;
  logic       flush_b, sleep_b, halted_b;

  rvx_core_state_ctrl #(
    .RESET_CYCLES(3), .FLUSH_CYCLES(4), .ENABLE_WFI(1'b1), .ENABLE_DEBUG(1'b1)
  ) dut_a (
    .clock(clock), .reset(reset), .clock_enable(clock_enable),
    .mret_s1(mret), .take_trap_s1(take_trap), .wfi_s1(wfi),
    .interrupt_pending(irq), .halt_req(halt_req), .resume_req(resume_req),
    .core_state_s1(state_a), .flush_pipeline_s1(flush_a),
    .sleeping(sleep_a), .halted(halted_a)
  );

  rvx_core_state_ctrl #(
    .RESET_CYCLES(1), .FLUSH_CYCLES(2), .ENABLE_WFI(1'b0), .ENABLE_DEBUG(1'b0)
  ) dut_b (
    .clock(clock), .reset(reset_b), .clock_enable(1'b1),
    .mret_s1(1'b0), .take_trap_s1(trap_b), .wfi_s1(wfi_b),
    .interrupt_pending(1'b0), .halt_req(halt_b), .resume_req(1'b0),
    .core_state_s1(state_b), .flush_pipeline_s1(flush_b),
    .sleeping(sleep_b), .halted(halted_b)
  );

  typedef struct {
    string tag;
    int    dut;
    int    state;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Push the expected state for this cycle, clock once, then pop and compare.
  task automatic step(input string tag, input int dut, input int exp_state);
    exp_t e;
    exp_t got;
    logic [3:0] st;
    logic fl, sl, hl;
    e.tag   = tag;
    e.dut   = dut;
    e.state = exp_state;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    got = sb_q.pop_front();
    if (got.dut == 0) begin
      st = state_a; fl = flush_a; sl = sleep_a; hl = halted_a;
    end else begin
      st = state_b; fl = flush_b; sl = sleep_b; hl = halted_b;
    end
    check_val({got.tag, ".state"},    32'(st), 32'(got.state));
    check_val({got.tag, ".flush"},    32'(fl), 32'(got.state != 1));
    check_val({got.tag, ".sleeping"}, 32'(sl), 32'(got.state == 4));
    check_val({got.tag, ".halted"},   32'(hl), 32'(got.state == 5));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; clock_enable = 1'b1; mret = 1'b0; take_trap = 1'b0;
    wfi = 1'b0; irq = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    reset_b = 1'b1; trap_b = 1'b0; wfi_b = 1'b0; halt_b = 1'b0;

    // Reset dwell: 3 enabled cycles in RESET.
    step("rst", 0, 0);
    reset = 1'b0;
    step("rst_d1", 0, 0);
    step("rst_d2", 0, 0);
    step("rst_exit", 0, 1);
    step("op_idle", 0, 1);

    // Trap entry: 4 cycles of TRAP_TAKEN.
    take_trap = 1'b1; step("trap_in", 0, 2);
    take_trap = 1'b0; step("trap_d1", 0, 2);
    step("trap_d2", 0, 2);
    step("trap_d3", 0, 2);
    step("trap_exit", 0, 1);

    // Trap return: 4 cycles of TRAP_RETURN.
    mret = 1'b1; step("mret_in", 0, 3);
    mret = 1'b0; step("mret_d1", 0, 3);
    step("mret_d2", 0, 3);
    step("mret_d3", 0, 3);
    step("mret_exit", 0, 1);

    // Trap has priority over MRET.
    take_trap = 1'b1; mret = 1'b1; step("both_in", 0, 2);
    take_trap = 1'b0; mret = 1'b0; step("both_d1", 0, 2);
    step("both_d2", 0, 2);
    step("both_d3", 0, 2);
    step("both_exit", 0, 1);

    // WFI sleep, wake on interrupt after five cycles.
    wfi = 1'b1; step("wfi_in", 0, 4);
    wfi = 1'b0;
    for (int i = 0; i < 5; i++) step("wfi_sleep", 0, 4);
    irq = 1'b1; step("wfi_wake", 0, 1);
    wfi = 1'b1; step("wfi_irq_noop", 0, 1);
    wfi = 1'b0; irq = 1'b0; step("wfi_after", 0, 1);

    // Halt requested during trap dwell is deferred until OPERATING.
    take_trap = 1'b1; step("hdw_in", 0, 2);
    take_trap = 1'b0; halt_req = 1'b1; wfi = 1'b1; mret = 1'b1;
    step("hdw_d1", 0, 2);
    step("hdw_d2", 0, 2);
    step("hdw_d3", 0, 2);
    wfi = 1'b0; mret = 1'b0;
    step("hdw_op", 0, 1);
    step("hdw_halt", 0, 5);
    resume_req = 1'b1; step("halt_hold", 0, 5);
    halt_req = 1'b0; step("halt_resume", 0, 1);
    resume_req = 1'b0; step("halt_after", 0, 1);

    // Halt has priority over interrupt wake in WFI_SLEEP.
    wfi = 1'b1; step("wh_sleep", 0, 4);
    wfi = 1'b0; halt_req = 1'b1; irq = 1'b1; step("wh_halt", 0, 5);
    halt_req = 1'b0; irq = 1'b0; resume_req = 1'b1; step("wh_resume", 0, 1);
    resume_req = 1'b0;

    // clock_enable low freezes the dwell mid-way.
    take_trap = 1'b1; step("ce_in", 0, 2);
    take_trap = 1'b0; step("ce_d1", 0, 2);
    clock_enable = 1'b0; mret = 1'b1; wfi = 1'b1;
    step("ce_hold1", 0, 2);
    step("ce_hold2", 0, 2);
    step("ce_hold3", 0, 2);
    clock_enable = 1'b1; wfi = 1'b0;
    step("ce_d2", 0, 2);
    mret = 1'b0;
    step("ce_d3", 0, 2);
    step("ce_exit", 0, 1);

    // Reset from WFI_SLEEP.
    wfi = 1'b1; step("rs4_sleep", 0, 4);
    wfi = 1'b0; reset = 1'b1; step("rs4_rst", 0, 0);
    reset = 1'b0;
    step("rs4_d1", 0, 0);
    step("rs4_d2", 0, 0);
    step("rs4_exit", 0, 1);

    // Reset from DEBUG_HALT with clock_enable low.
    halt_req = 1'b1; step("rs5_halt", 0, 5);
    reset = 1'b1; clock_enable = 1'b0; step("rs5_rst", 0, 0);
    reset = 1'b0; clock_enable = 1'b1; halt_req = 1'b0;
    step("rs5_d1", 0, 0);
    step("rs5_d2", 0, 0);
    step("rs5_exit", 0, 1);

    // Reset mid trap dwell with clock_enable low.
    take_trap = 1'b1; step("rs2_in", 0, 2);
    take_trap = 1'b0; step("rs2_d1", 0, 2);
    reset = 1'b1; clock_enable = 1'b0; step("rs2_rst", 0, 0);
    reset = 1'b0; step("rs2_ce_hold", 0, 0);
    clock_enable = 1'b1;
    step("rs2_d1b", 0, 0);
    step("rs2_d2b", 0, 0);
    step("rs2_exit", 0, 1);

    // Instance B: WFI and debug disabled, short dwells.
    step("b_rst", 1, 0);
    reset_b = 1'b0; step("b_run", 1, 1);
    wfi_b = 1'b1; step("b_wfi_off", 1, 1);
    wfi_b = 1'b0; halt_b = 1'b1; step("b_dbg_off", 1, 1);
    trap_b = 1'b1; step("b_trap", 1, 2);
    trap_b = 1'b0; step("b_dwell", 1, 2);
    step("b_exit", 1, 1);
    step("b_stay", 1, 1);
    halt_b = 1'b0;

    if (sb_q.size() != 0) check_val("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
